cfg_chain_shifter: RTL and testbench

//  Serial configuration-chain master feeding the DUT pins config_clk, config_in and config_load in fw_top.

---
 rtl/cfg_chain_shifter.sv | 174 +++++++++++++++++
 tb/tb_cfg_chain_shifter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/cfg_chain_shifter.sv
// cfg_chain_shifter: serial configuration-chain master.
// Shifts a CHAIN_LEN-bit word MSB-first out on config_in under a divided
// config_clk. It captures config_out on every rising config_clk, then strobes
// config_load. The captured word appears on data_out together with done.
// Ports:
//   S_AXI_ACLK / S_AXI_ARESETN : system clock, async active-low reset
//   start, data_in             : one-cycle request and word to shift
//   busy, done, data_out       : transfer status and captured readback
//   config_clk/in/load         : serial pins driven to the chain
//   config_out                 : serial readback from the chain
module cfg_chain_shifter #(
  parameter int unsigned CHAIN_LEN = 64,
  parameter int unsigned CLK_DIV   = 4
) (
  input  logic                 S_AXI_ACLK,
  input  logic                 S_AXI_ARESETN,
  input  logic                 start,
  input  logic [CHAIN_LEN-1:0] data_in,
  output logic                 busy,
  output logic                 done,
  output logic [CHAIN_LEN-1:0] data_out,
  output logic                 config_clk,
  output logic                 config_in,
  output logic                 config_load,
  input  logic                 config_out
);

  localparam int unsigned BIT_W = $clog2(CHAIN_LEN + 1);
  localparam int unsigned DIV_W = $clog2(CLK_DIV + 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SHIFT_LO = 3'd1,
    SHIFT_HI = 3'd2,
    SETTLE   = 3'd3,
    LOAD     = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [CHAIN_LEN-1:0] tx_q, tx_d;
  logic [CHAIN_LEN-1:0] rx_q, rx_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [CHAIN_LEN-1:0] dout_q, dout_d;
  logic                 cclk_q, cclk_d;
  logic                 cin_q, cin_d;
  logic                 load_q, load_d;

  logic                 div_last_c;
  logic [BIT_W-1:0]     bit_inc_c;

  assign div_last_c = (div_q == DIV_W'(CLK_DIV - 1));
  assign bit_inc_c  = bit_q + BIT_W'(1);

  // State and datapath registers
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q <= IDLE;
      tx_q    <= '0;
      rx_q    <= '0;
      bit_q   <= '0;
      div_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dout_q  <= '0;
      cclk_q  <= 1'b0;
      cin_q   <= 1'b0;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      bit_q   <= bit_d;
      div_q   <= div_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dout_q  <= dout_d;
      cclk_q  <= cclk_d;
      cin_q   <= cin_d;
      load_q  <= load_d;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    bit_d   = bit_q;
    div_d   = div_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dout_d  = dout_q;
    cclk_d  = cclk_q;
    cin_d   = cin_q;
    load_d  = load_q;

    unique case (state_q)
      IDLE: begin
        // A start coinciding with done is dropped; the next cycle may start.
        if (start && !done_q) begin
          tx_d    = data_in;
          bit_d   = '0;
          div_d   = '0;
          busy_d  = 1'b1;
          cclk_d  = 1'b0;
          cin_d   = data_in[CHAIN_LEN-1];
          state_d = SHIFT_LO;
        end
      end
      SHIFT_LO: begin
        if (div_last_c) begin
          // Readback is sampled on the same edge that raises config_clk.
          div_d   = '0;
          cclk_d  = 1'b1;
          rx_d    = {rx_q[CHAIN_LEN-2:0], config_out};
          state_d = SHIFT_HI;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      SHIFT_HI: begin
        if (div_last_c) begin
          div_d  = '0;
          bit_d  = bit_inc_c;
          cclk_d = 1'b0;
          // config_in only moves on the falling edge, keeping setup/hold wide.
          if (bit_inc_c < BIT_W'(CHAIN_LEN)) begin
            tx_d    = {tx_q[CHAIN_LEN-2:0], 1'b0};
            cin_d   = tx_q[CHAIN_LEN-2];
            state_d = SHIFT_LO;
          end else begin
            cin_d   = 1'b0;
            state_d = SETTLE;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      SETTLE: begin
        if (div_last_c) begin
          div_d   = '0;
          load_d  = 1'b1;
          state_d = LOAD;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      LOAD: begin
        if (div_last_c) begin
          div_d   = '0;
          load_d  = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          dout_d  = rx_q;
          state_d = IDLE;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign data_out    = dout_q;
  assign config_clk  = cclk_q;
  assign config_in   = cin_q;
  assign config_load = load_q;

endmodule

// File: tb/tb_cfg_chain_shifter.sv
// Bench for cfg_chain_shifter: an 8-bit/CLK_DIV=2 instance and a
// 4-bit/CLK_DIV=1 instance, each attached to a behavioural chain register.
module tb_cfg_chain_shifter;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance A: CHAIN_LEN=8, CLK_DIV=2
  logic       start_a, busy_a, done_a, cclk_a, cin_a, load_a, cout_a;
  logic [7:0] din_a, dout_a;
  // Instance B: CHAIN_LEN=4, CLK_DIV=1
  logic       start_b, busy_b, done_b, cclk_b, cin_b, load_b, cout_b;
  logic [3:0] din_b, dout_b;

  cfg_chain_shifter #(.CHAIN_LEN(8), .CLK_DIV(2)) u_a (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .start(start_a), .data_in(din_a),
    .busy(busy_a), .done(done_a), .data_out(dout_a), .config_clk(cclk_a),
    .config_in(cin_a), .config_load(load_a), .config_out(cout_a));

  cfg_chain_shifter #(.CHAIN_LEN(4), .CLK_DIV(1)) u_b (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .start(start_b), .data_in(din_b),
    .busy(busy_b), .done(done_b), .data_out(dout_b), .config_clk(cclk_b),
    .config_in(cin_b), .config_load(load_b), .config_out(cout_b));

  // Behavioural chains: shift in config_in on each rising config_clk, MSB out.
  logic [7:0] mdl_a = 8'h3C;
  logic [3:0] mdl_b = 4'hC;
  always @(posedge cclk_a) mdl_a <= {mdl_a[6:0], cin_a};
  always @(posedge cclk_b) mdl_b <= {mdl_b[2:0], cin_b};
  assign cout_a = mdl_a[7];
  assign cout_b = mdl_b[3];

  // Selected-instance view used by the transfer task
  logic       sel;
  logic       m_busy, m_done, m_cclk, m_cin, m_load;
  logic [7:0] m_dout, m_mdl;
  always_comb begin
    m_busy = sel ? busy_b : busy_a;
    m_done = sel ? done_b : done_a;
    m_cclk = sel ? cclk_b : cclk_a;
    m_cin  = sel ? cin_b  : cin_a;
    m_load = sel ? load_b : load_a;
    m_dout = sel ? {4'h0, dout_b} : dout_a;
    m_mdl  = sel ? {4'h0, mdl_b}  : mdl_a;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic drive(input logic s, input logic v, input logic [7:0] d);
    if (s) begin start_b = v; din_b = d[3:0]; end
    else   begin start_a = v; din_a = d; end
  endtask

  // One full transfer, entered at a negedge; returns at the negedge of done.
  task automatic run_xfer(input logic s, input logic [7:0] din, input logic [7:0] exp_dout,
                          input int exp_lat, input bit poke);
    int n, d, c, lat, rises, hi_len, hi_bad, load_len, busy_bad, cin_bad;
    logic [7:0] seq, mask;
    logic prev_clk, prev_cin, seen;
    sel  = s;
    n    = s ? 4 : 8;
    d    = s ? 1 : 2;
    mask = s ? 8'h0F : 8'hFF;
    drive(s, 1'b1, din);
    c = cyc;
    lat = -1; rises = 0; hi_len = 0; hi_bad = 0; load_len = 0; busy_bad = 0; cin_bad = 0;
    seq = '0; prev_clk = 1'b0; prev_cin = 1'b0; seen = 1'b0;
    for (int k = 1; k <= 200 && !seen; k++) begin
      @(negedge clk);
      if (k == 1) drive(s, 1'b0, ~din);
      if (poke && k == 10) drive(s, 1'b1, ~din);
      if (poke && k == 11) drive(s, 1'b0, din);
      if (m_done) begin
        seen = 1'b1;
        lat  = cyc - c;
        check("busy_low_at_done", 32'(m_busy), 32'd0);
      end else if (!m_busy) begin
        busy_bad++;
      end
      if (m_cclk && !prev_clk) begin
        rises++;
        seq    = {seq[6:0], m_cin};
        hi_len = 1;
      end else if (m_cclk) begin
        hi_len++;
      end else if (prev_clk && hi_len != d) begin
        hi_bad++;
      end
      if (m_cclk && (m_cin != prev_cin)) cin_bad++;
      if (m_load) load_len++;
      prev_clk = m_cclk;
      prev_cin = m_cin;
    end
    check("done_latency",  32'(lat),      32'(exp_lat));
    check("clk_rises",     32'(rises),    32'(n));
    check("cin_sequence",  32'(seq),      32'(din & mask));
    check("clk_high_len",  32'(hi_bad),   32'd0);
    check("cin_stable_hi", 32'(cin_bad),  32'd0);
    check("load_len",      32'(load_len), 32'(d));
    check("busy_during",   32'(busy_bad), 32'd0);
    check("data_out",      32'(m_dout),   32'(exp_dout & mask));
    check("chain_model",   32'(m_mdl),    32'(din & mask));
  endtask

  typedef struct {
    logic       s;
    logic [7:0] din;
    logic [7:0] exp_dout;
    int         exp_lat;
    bit         b2b;
    bit         poke;
  } vec_t;

  vec_t vecs_a[3];
  vec_t vecs_b[2];
  logic [7:0] ref_a, ref_b, rd;
  int rises;
  logic prev;

  initial begin
    vecs_a[0] = '{1'b0, 8'hA5, 8'h3C, 37, 1'b0, 1'b0};
    vecs_a[1] = '{1'b0, 8'h5A, 8'hA5, 37, 1'b1, 1'b0};
    vecs_a[2] = '{1'b0, 8'hC3, 8'h5A, 37, 1'b0, 1'b1};
    vecs_b[0] = '{1'b1, 8'h06, 8'h0C, 11, 1'b0, 1'b0};
    vecs_b[1] = '{1'b1, 8'h03, 8'h06, 11, 1'b1, 1'b0};
    sel = 1'b0;

    // Reset held with start asserted: everything stays at zero.
    rst_n = 1'b0; start_a = 1'b1; start_b = 1'b1; din_a = 8'hFF; din_b = 4'hF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("reset_outs_a", {26'd0, busy_a, done_a, cclk_a, cin_a, load_a, |dout_a}, 32'd0);
      check("reset_outs_b", {26'd0, busy_b, done_b, cclk_b, cin_b, load_b, |dout_b}, 32'd0);
    end
    start_a = 1'b0; start_b = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table for instance A
    for (int i = 0; i < 3; i++) begin
      sel = vecs_a[i].s;
      if (vecs_a[i].b2b) begin
        drive(vecs_a[i].s, 1'b1, 8'h81);  // start on the done cycle must be ignored
        @(negedge clk);
        check("start_on_done_ignored", 32'(m_busy), 32'd0);
      end else begin
        @(negedge clk);
      end
      run_xfer(vecs_a[i].s, vecs_a[i].din, vecs_a[i].exp_dout, vecs_a[i].exp_lat, vecs_a[i].poke);
    end
    ref_a = 8'hC3;

    // Abort after the third rising config_clk
    @(negedge clk);
    sel = 1'b0;
    drive(1'b0, 1'b1, 8'h0F);
    rises = 0; prev = 1'b0;
    for (int k = 1; k <= 200 && rises < 3; k++) begin
      @(negedge clk);
      if (k == 1) drive(1'b0, 1'b0, 8'h0F);
      if (cclk_a && !prev) rises++;
      prev = cclk_a;
    end
    check("abort_rises", 32'(rises), 32'd3);
    rst_n = 1'b0;
    #1;
    check("abort_outs_zero", {26'd0, busy_a, done_a, cclk_a, cin_a, load_a, |dout_a}, 32'd0);
    ref_a = (ref_a << 3) | (8'h0F >> 5);
    check("abort_chain_model", 32'(mdl_a), 32'(ref_a));
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 2) rst_n = 1'b1;
      check("abort_no_done", {30'd0, done_a, busy_a}, 32'd0);
    end
    run_xfer(1'b0, 8'hFF, ref_a, 37, 1'b0);
    ref_a = 8'hFF;

    // Directed table for instance B
    for (int i = 0; i < 2; i++) begin
      sel = vecs_b[i].s;
      if (vecs_b[i].b2b) begin
        drive(vecs_b[i].s, 1'b1, 8'h0F);
        @(negedge clk);
        check("start_on_done_ignored_b", 32'(m_busy), 32'd0);
      end else begin
        @(negedge clk);
      end
      run_xfer(vecs_b[i].s, vecs_b[i].din, vecs_b[i].exp_dout, vecs_b[i].exp_lat, vecs_b[i].poke);
    end
    ref_b = 8'h03;

    // Random transfers: readback must equal the word the chain held before.
    for (int i = 0; i < 6; i++) begin
      rd = 8'($urandom);
      @(negedge clk);
      if (i[0]) begin
        run_xfer(1'b1, rd, ref_b, 11, 1'b0);
        ref_b = rd & 8'h0F;
      end else begin
        run_xfer(1'b0, rd, ref_a, 37, 1'b0);
        ref_a = rd;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
